riscv_core_muxnx1_pipe: RTL and testbench
=========================================

RISCV_CORE_MUXNX1_PIPE -- requirements
Module: riscv_core_muxnx1_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NUM_IN, default 3, number of data inputs; legal range 2..16.
REQ-003 SHALL have localparam SEL_W = $clog2(NUM_IN), the select width.
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_mux_in  input  NUM_IN*XLEN  flattened inputs; input k occupies bits [k*XLEN +: XLEN].
REQ-007 SHALL have port i_mux_sel  input  SEL_W  binary select.
REQ-008 SHALL have port i_mux_valid  input  1  upstream presents in/sel this cycle.
REQ-009 SHALL have port o_mux_ready  output  1  block can accept this cycle.
REQ-010 SHALL have port o_mux_out  output  XLEN  selected, registered data.
REQ-011 SHALL have port o_mux_sel_err  output  1  held beat was captured with i_mux_sel >= NUM_IN.
REQ-012 SHALL have port o_mux_valid  output  1  o_mux_out/o_mux_sel_err are valid.
REQ-013 SHALL have port i_mux_ready  input  1  downstream accepts this cycle.
REQ-014 SHALL have port i_mux_flush  input  1  synchronous discard of all held and incoming beats.

Function
REQ-015 SHALL accept a beat when i_mux_valid && o_mux_ready, capturing input[i_mux_sel] and the error flag.
REQ-016 SHALL, for i_mux_sel >= NUM_IN, capture input 0 and set the beat's sel_err bit to 1.
REQ-017 SHALL present an accepted beat on o_mux_valid exactly 1 cycle after acceptance when the output stage is empty.
REQ-018 SHALL complete an output transfer when o_mux_valid && i_mux_ready.
REQ-019 SHALL hold o_mux_out, o_mux_sel_err and o_mux_valid stable while o_mux_valid && !i_mux_ready.
REQ-020 SHALL deliver beats in acceptance order, with no loss or duplication.
REQ-021 SHALL sustain one beat per cycle when i_mux_ready is continuously 1.
REQ-022 SHALL, on i_mux_flush=1, clear all valid state at the next edge.
REQ-023 SHALL give i_mux_flush priority over a simultaneous accept; the incoming beat is dropped.
REQ-024 SHALL give i_mux_flush priority over a simultaneous output transfer; the beat counts as consumed by downstream.
REQ-025 SHALL, when the output stage is full, i_mux_ready=1 and a new beat is accepted in the same cycle, replace the held beat with the new beat (no bubble).
REQ-026 SHALL keep o_mux_out at its last value when o_mux_valid=0; the value is don't-care for the consumer.

Reset
REQ-027 SHALL, while i_rst=1, force o_mux_valid=0, o_mux_out=0, o_mux_sel_err=0 and all internal valid bits to 0, independent of i_clk.
REQ-028 SHALL drive o_mux_ready=1 during and immediately after reset.
REQ-029 SHALL discard any in-flight beat when reset is asserted mid-stall; no beat emerges after release until a new accept.

Configuration
REQ-030 SHALL use the macro RISCV_CORE_MUX_SKID_EN to select the buffering scheme.
REQ-031 SHALL, with RISCV_CORE_MUX_SKID_EN defined, implement a 2-entry buffer: main register plus skid register.
REQ-032 SHALL, in skid mode, register o_mux_ready as !skid_valid, with no combinational path from i_mux_ready.
REQ-033 SHALL, in skid mode, load an accepted beat into the skid register when main is full and not draining.
REQ-034 SHALL, in skid mode, move the skid entry into main on the next transfer.
REQ-035 SHALL, without the macro, implement a single register with o_mux_ready = !o_mux_valid || i_mux_ready (combinational).
REQ-036 SHALL preserve REQ-015..REQ-029 in both modes.

Verification
REQ-037 SHALL cover streaming: NUM_IN=3, in0/1/2 = 0x11/0x22/0x33, sel 0,1,2,0 on consecutive cycles, i_mux_ready=1 -> o_mux_out 0x11,0x22,0x33,0x11 on cycles 1..4 with o_mux_valid=1 and no gaps.
REQ-038 SHALL cover an out-of-range select: sel=3, in0=0xA5 -> o_mux_out=0xA5, o_mux_sel_err=1 on the following cycle.
REQ-039 SHALL cover backpressure: beats 0x22,0x33 accepted, i_mux_ready=0 for 3 cycles -> 0x22 held stable.
REQ-040 SHALL cover backpressure with skid enabled: o_mux_ready drops to 0 after the 2nd beat; on release, 0x22 then 0x33 are delivered.
REQ-041 SHALL cover flush: flush asserted with 2 beats held and i_mux_valid=1 -> next cycle o_mux_valid=0, o_mux_ready=1, and no beat later appears.
REQ-042 SHALL cover reset: i_rst asserted mid-stall between clock edges -> o_mux_valid=0 and o_mux_out=0 immediately; after release, o_mux_ready=1 and no beat emerges.

Source files
------------

// File: rtl/riscv_core_muxnx1_pipe.sv
// N:1 pipelined mux with valid/ready handshake on both sides.
// Define RISCV_CORE_MUX_SKID_EN for the 2-entry main+skid buffer with registered ready.
module riscv_core_muxnx1_pipe #(
    parameter  int unsigned XLEN   = 32,
    parameter  int unsigned NUM_IN = 3,
    localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_IN*XLEN-1:0] i_mux_in,
    input  logic [SEL_W-1:0]       i_mux_sel,
    input  logic                   i_mux_valid,
    output logic                   o_mux_ready,
    output logic [XLEN-1:0]        o_mux_out,
    output logic                   o_mux_sel_err,
    output logic                   o_mux_valid,
    input  logic                   i_mux_ready,
    input  logic                   i_mux_flush
);

    typedef struct packed {
        logic            sel_err;
        logic [XLEN-1:0] data;
    } beat_t;

    beat_t in_beat;
    beat_t main_q, main_d;
    logic  main_vld_q, main_vld_d;
    logic  accept;
    logic  xfer;

    // Out-of-range selects fall back to input 0 and flag the beat.
    always_comb begin
        in_beat.data    = i_mux_in[XLEN-1:0];
        in_beat.sel_err = !(32'(i_mux_sel) < NUM_IN);
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (i_mux_sel == SEL_W'(k)) begin
                in_beat.data = i_mux_in[k*XLEN +: XLEN];
            end
        end
    end

    assign accept        = i_mux_valid && o_mux_ready;
    assign xfer          = main_vld_q && i_mux_ready;
    assign o_mux_out     = main_q.data;
    assign o_mux_sel_err = main_q.sel_err;
    assign o_mux_valid   = main_vld_q;

`ifdef RISCV_CORE_MUX_SKID_EN
    beat_t skid_q, skid_d;
    logic  skid_vld_q, skid_vld_d;

    // Main refills from skid first so ordering is kept; skid only fills when main is stuck.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (i_mux_flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || xfer) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = in_beat;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = in_beat;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            main_q      <= '0;
            main_vld_q  <= 1'b0;
            skid_q      <= '0;
            skid_vld_q  <= 1'b0;
            o_mux_ready <= 1'b1;
        end else begin
            main_q      <= main_d;
            main_vld_q  <= main_vld_d;
            skid_q      <= skid_d;
            skid_vld_q  <= skid_vld_d;
            o_mux_ready <= !skid_vld_d;
        end
    end
`else
    assign o_mux_ready = !main_vld_q || i_mux_ready;

    // Single stage: a new beat may replace the held one in the cycle it drains.
    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        if (i_mux_flush) begin
            main_vld_d = 1'b0;
        end else if (accept) begin
            main_d     = in_beat;
            main_vld_d = 1'b1;
        end else if (i_mux_ready) begin
            main_vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_core_muxnx1_pipe.sv
// Directed self-checking bench for riscv_core_muxnx1_pipe (NUM_IN=3, XLEN=32).
// Expectations branch on RISCV_CORE_MUX_SKID_EN where the buffering scheme differs.
module tb_riscv_core_muxnx1_pipe;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NUM_IN = 3;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic [NUM_IN*XLEN-1:0] i_mux_in;
    logic [1:0]             i_mux_sel;
    logic                   i_mux_valid;
    logic                   o_mux_ready;
    logic [XLEN-1:0]        o_mux_out;
    logic                   o_mux_sel_err;
    logic                   o_mux_valid;
    logic                   i_mux_ready;
    logic                   i_mux_flush;

    int n_cmp = 0;
    int n_err = 0;

    riscv_core_muxnx1_pipe #(.XLEN(XLEN), .NUM_IN(NUM_IN)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_mux_in     (i_mux_in),
        .i_mux_sel    (i_mux_sel),
        .i_mux_valid  (i_mux_valid),
        .o_mux_ready  (o_mux_ready),
        .o_mux_out    (o_mux_out),
        .o_mux_sel_err(o_mux_sel_err),
        .o_mux_valid  (o_mux_valid),
        .i_mux_ready  (i_mux_ready),
        .i_mux_flush  (i_mux_flush)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] d, input logic e);
        check_eq({tag, ".valid"}, 32'(o_mux_valid), 32'(v));
        check_eq({tag, ".out"}, o_mux_out, d);
        check_eq({tag, ".err"}, 32'(o_mux_sel_err), 32'(e));
    endtask

    initial begin
        i_rst       = 1'b1;
        i_mux_in    = {32'h33, 32'h22, 32'h11};
        i_mux_sel   = 2'd0;
        i_mux_valid = 1'b0;
        i_mux_ready = 1'b1;
        i_mux_flush = 1'b0;
        #1;
        check_out("rst", 1'b0, 32'h0, 1'b0);
        check_eq("rst.ready", 32'(o_mux_ready), 32'd1);
        #11;
        i_rst = 1'b0;
        check_eq("post_rst.ready", 32'(o_mux_ready), 32'd1);

        // Streaming at one beat per cycle
        i_mux_valid = 1'b1;
        i_mux_sel   = 2'd0;
        tick(); check_out("s0", 1'b1, 32'h11, 1'b0);
        i_mux_sel = 2'd1;
        tick(); check_out("s1", 1'b1, 32'h22, 1'b0);
        i_mux_sel = 2'd2;
        tick(); check_out("s2", 1'b1, 32'h33, 1'b0);
        i_mux_sel = 2'd0;
        tick(); check_out("s3", 1'b1, 32'h11, 1'b0);
        i_mux_valid = 1'b0;
        tick(); check_out("s_idle", 1'b0, 32'h11, 1'b0);

        // Out-of-range select falls back to input 0
        i_mux_in    = {32'h33, 32'h22, 32'hA5};
        i_mux_sel   = 2'd3;
        i_mux_valid = 1'b1;
        tick(); check_out("oor", 1'b1, 32'hA5, 1'b1);
        i_mux_valid = 1'b0;
        i_mux_in    = {32'h33, 32'h22, 32'h11};
        tick(); check_eq("oor_idle.valid", 32'(o_mux_valid), 32'd0);

        // Backpressure: 0x22 held for 3 stalled cycles, then 0x33 follows
        i_mux_ready = 1'b0;
        i_mux_valid = 1'b1;
        i_mux_sel   = 2'd1;
        tick(); check_out("bp0", 1'b1, 32'h22, 1'b0);
        i_mux_sel = 2'd2;
`ifdef RISCV_CORE_MUX_SKID_EN
        check_eq("bp0.ready", 32'(o_mux_ready), 32'd1);
        tick(); check_out("bp1", 1'b1, 32'h22, 1'b0);
        check_eq("bp1.ready", 32'(o_mux_ready), 32'd0);
        i_mux_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(); check_out("bp_hold", 1'b1, 32'h22, 1'b0);
            check_eq("bp_hold.ready", 32'(o_mux_ready), 32'd0);
        end
        i_mux_ready = 1'b1;
        tick(); check_out("bp_rel", 1'b1, 32'h33, 1'b0);
        check_eq("bp_rel.ready", 32'(o_mux_ready), 32'd1);
`else
        check_eq("bp0.ready", 32'(o_mux_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); check_out("bp_hold", 1'b1, 32'h22, 1'b0);
            check_eq("bp_hold.ready", 32'(o_mux_ready), 32'd0);
        end
        i_mux_ready = 1'b1;
        #1;
        check_eq("bp_rel.ready_comb", 32'(o_mux_ready), 32'd1);
        tick(); check_out("bp_rel", 1'b1, 32'h33, 1'b0);
        i_mux_valid = 1'b0;
`endif
        tick(); check_eq("bp_drain.valid", 32'(o_mux_valid), 32'd0);

        // Flush with held beats and a simultaneous incoming beat
        i_mux_ready = 1'b0;
        i_mux_valid = 1'b1;
        i_mux_sel   = 2'd0;
        tick(); check_out("fl0", 1'b1, 32'h11, 1'b0);
`ifdef RISCV_CORE_MUX_SKID_EN
        i_mux_sel = 2'd1;
        tick(); check_eq("fl1.ready", 32'(o_mux_ready), 32'd0);
`endif
        i_mux_sel   = 2'd2;
        i_mux_flush = 1'b1;
        i_mux_ready = 1'b1;
        tick();
        check_eq("flush.valid", 32'(o_mux_valid), 32'd0);
        check_eq("flush.ready", 32'(o_mux_ready), 32'd1);
        i_mux_flush = 1'b0;
        i_mux_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check_eq("flush_after.valid", 32'(o_mux_valid), 32'd0);
        end

        // Reset asserted mid-stall between clock edges
        i_mux_ready = 1'b0;
        i_mux_valid = 1'b1;
        i_mux_sel   = 2'd2;
        tick(); check_out("rs0", 1'b1, 32'h33, 1'b0);
        i_mux_valid = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        check_out("rs_async", 1'b0, 32'h0, 1'b0);
        check_eq("rs_async.ready", 32'(o_mux_ready), 32'd1);
        #3;
        i_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("rs_after.valid", 32'(o_mux_valid), 32'd0);
            check_eq("rs_after.ready", 32'(o_mux_ready), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
